// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared constants for the ALU control unit: ALU operation codes, R-type
// func field codes, ALUOp encodings and the sequencing FSM state type.
package alu_ctrl_pkg;

    // ALU operation codes driven to the datapath
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_NOP = 4'b1111;

    // R-type func field codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_DIV = 6'b011010;

    // ALUOp encodings from the main control unit
    localparam logic [1:0] ALUOP_LS    = 2'b00;  // load/store address add
    localparam logic [1:0] ALUOP_BR    = 2'b01;  // branch compare subtract
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode func
    localparam logic [1:0] ALUOP_IMM   = 2'b11;  // immediate OR

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_func_decode.sv
// alu_func_decode
// Purely combinational decode of ALUOp/func into an ALU operation code,
// plus flags for multi-cycle operations (MUL/DIV) and illegal func values.
// Ports:
//   alu_op   in   2       ALUOp from main control
//   func     in   FUNC_W  R-type function field
//   op_code  out  OP_W    decoded operation (NOP when illegal)
//   is_multi out  1       operation needs iterative sequencing
//   illegal  out  1       R-type func not recognised
module alu_func_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W = 6,
    parameter int OP_W   = 4
) (
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] func,
    output logic [OP_W-1:0]   op_code,
    output logic              is_multi,
    output logic              illegal
);

    always_comb begin
        op_code  = OP_W'(OP_NOP);
        is_multi = 1'b0;
        illegal  = 1'b0;
        case (alu_op)
            ALUOP_LS:  op_code = OP_W'(OP_ADD);
            ALUOP_BR:  op_code = OP_W'(OP_SUB);
            ALUOP_IMM: op_code = OP_W'(OP_OR);
            default: begin
                case (func)
                    FUNC_W'(FN_ADD): op_code = OP_W'(OP_ADD);
                    FUNC_W'(FN_SUB): op_code = OP_W'(OP_SUB);
                    FUNC_W'(FN_AND): op_code = OP_W'(OP_AND);
                    FUNC_W'(FN_OR):  op_code = OP_W'(OP_OR);
                    FUNC_W'(FN_NOR): op_code = OP_W'(OP_NOR);
                    FUNC_W'(FN_SLT): op_code = OP_W'(OP_SLT);
                    FUNC_W'(FN_MUL): begin
                        op_code  = OP_W'(OP_MUL);
                        is_multi = 1'b1;
                    end
                    FUNC_W'(FN_DIV): begin
                        op_code  = OP_W'(OP_DIV);
                        is_multi = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_control_mc.sv
// alu_control_mc
// Registered, handshaked ALU control with multi-cycle sequencing for MUL
// (shift-add) and DIV (restoring), each taking DATA_W iteration cycles.
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   start      in   1       issue strobe, honoured when not stalled
//   ALUOp      in   2       operation class from main control
//   func       in   FUNC_W  R-type function field
//   operation  out  OP_W    registered ALU operation code
//   iter_en    out  1       datapath performs one MUL/DIV step
//   iter_first out  1       first step; datapath loads operands
//   iter_last  out  1       final step
//   stall      out  1       busy; upstream holds the instruction
//   done       out  1       one-cycle result-valid pulse
//   err        out  1       pulses with done on an illegal func
module alu_control_mc
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FUNC_W = 6,
    parameter int OP_W   = 4,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        ALUOp,
    input  logic [FUNC_W-1:0] func,
    output logic [OP_W-1:0]   operation,
    output logic              iter_en,
    output logic              iter_first,
    output logic              iter_last,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [OP_W-1:0]   op_reg, op_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic [OP_W-1:0]   dec_op;
    logic              dec_multi;
    logic              dec_illegal;

    alu_func_decode #(
        .FUNC_W (FUNC_W),
        .OP_W   (OP_W)
    ) u_decode (
        .alu_op   (ALUOp),
        .func     (func),
        .op_code  (dec_op),
        .is_multi (dec_multi),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= OP_W'(OP_NOP);
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            // FIN behaves like IDLE for a new issue, so back-to-back
            // instructions lose no cycle after a MUL/DIV completes.
            ST_IDLE, ST_FIN: begin
                state_next = ST_IDLE;
                if (start) begin
                    if (dec_illegal) begin
                        op_next   = OP_W'(OP_NOP);
                        done_next = 1'b1;
                        err_next  = 1'b1;
                    end else if (dec_multi) begin
                        op_next    = dec_op;
                        cnt_next   = '0;
                        state_next = ST_ITER;
                    end else begin
                        op_next   = dec_op;
                        done_next = 1'b1;
                    end
                end
            end
            ST_ITER: begin
                // Hold at the last count rather than wrapping; the counter
                // is re-cleared on the next ITER entry anyway.
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_FIN;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign operation  = op_reg;
    assign iter_en    = (state_reg == ST_ITER);
    assign iter_first = (state_reg == ST_ITER) && (cnt_reg == '0);
    assign iter_last  = (state_reg == ST_ITER) && (cnt_reg == CNT_LAST);
    assign stall      = (state_reg == ST_ITER);
    // done_reg covers single-cycle issues; FIN covers MUL/DIV completion.
    // They never coincide because any issue returns the FSM to IDLE.
    assign done       = done_reg | (state_reg == ST_FIN);
    assign err        = err_reg;

endmodule

// File: tb/tb_alu_control_mc.sv
module tb_alu_control_mc;

    typedef struct packed {
        logic [3:0] op;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [1:0] alu_op;
    logic [5:0] func;
    logic [3:0] operation;
    logic       iter_en, iter_first, iter_last, stall, done, err;

    logic       rst16, start16;
    logic [1:0] alu_op16;
    logic [5:0] func16;
    logic [3:0] operation16;
    logic       iter_en16, iter_first16, iter_last16, stall16, done16, err16;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_control_mc #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .ALUOp(alu_op), .func(func),
        .operation(operation), .iter_en(iter_en), .iter_first(iter_first),
        .iter_last(iter_last), .stall(stall), .done(done), .err(err)
    );

    alu_control_mc #(.DATA_W(16)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .ALUOp(alu_op16), .func(func16),
        .operation(operation16), .iter_en(iter_en16), .iter_first(iter_first16),
        .iter_last(iter_last16), .stall(stall16), .done(done16), .err(err16)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; alu_op = 2'b10; func = 6'b011000;
        rst16 = 1'b1; start16 = 1'b1; alu_op16 = 2'b10; func16 = 6'b011000;
        tick; tick;
        checks++;
        if (operation !== 4'b1111) begin
            errors++; $display("FAIL reset_op: got %b want 1111", operation);
        end
        checks++;
        if ({stall, done, err, iter_en, iter_first, iter_last} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000",
                               {stall, done, err, iter_en, iter_first, iter_last});
        end
        checks++;
        if ({operation16, stall16, done16, iter_en16} !== 7'b1111000) begin
            errors++; $display("FAIL reset16: got %b want 1111000",
                               {operation16, stall16, done16, iter_en16});
        end
        rst = 1'b0; start = 1'b0; rst16 = 1'b0; start16 = 1'b0;
        tick;
        checks++;
        if (done !== 1'b0 || operation !== 4'b1111) begin
            errors++; $display("FAIL reset_drop: done=%b op=%b want done=0 op=1111", done, operation);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_ops;
        logic [1:0] ta [9] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [5:0] tf [9] = '{6'b0, 6'b0, 6'b0, 6'b100000, 6'b100010, 6'b100100,
                               6'b100101, 6'b100111, 6'b101010};
        logic [3:0] to [9] = '{4'b0010, 4'b0110, 4'b0001, 4'b0010, 4'b0110, 4'b0000,
                               4'b0001, 4'b1100, 4'b0111};
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            alu_op = ta[i];
            func   = (i < 3) ? 6'($urandom) : tf[i];
            start  = 1'b1;
            sb.push_back('{op: to[i], err: 1'b0});
            tick;
            start = 1'b0;
            checks++;
            if (stall !== 1'b0) begin
                errors++; $display("FAIL single_stall[%0d]: got %b want 0", i, stall);
            end
            checks++;
            e = sb.pop_front();
            if (done !== 1'b1) begin
                errors++; $display("FAIL single_done[%0d]: got %b want 1", i, done);
            end else if (operation !== e.op || err !== e.err) begin
                errors++; $display("FAIL single_op[%0d]: got op=%b err=%b want op=%b err=%b",
                                   i, operation, err, e.op, e.err);
            end
            $display("single op %0d: ALUOp=%b func=%b -> op=%b done=%b", i, ta[i], func, operation, done);
        end
        tick;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL single_idle_done: got %b want 0", done);
        end
    endtask

    task automatic test_mul;
        exp_t e;
        logic [4:0] ev;
        int n_iter = 0;
        alu_op = 2'b10; func = 6'b011000; start = 1'b1;
        sb.push_back('{op: 4'b1000, err: 1'b0});
        tick;
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            ev = {c <= 8, c == 1, c == 8, c <= 8, c == 9};
            checks++;
            if ({iter_en, iter_first, iter_last, stall, done} !== ev) begin
                errors++; $display("FAIL mul_flags[c%0d]: got %b want %b", c,
                                   {iter_en, iter_first, iter_last, stall, done}, ev);
            end
            checks++;
            if (operation !== 4'b1000) begin
                errors++; $display("FAIL mul_op[c%0d]: got %b want 1000", c, operation);
            end
            if (iter_en === 1'b1) n_iter++;
            if (done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL mul_sb: unexpected done, got 1 want 0");
                end else begin
                    e = sb.pop_front();
                    if (err !== e.err) begin
                        errors++; $display("FAIL mul_err: got %b want %b", err, e.err);
                    end
                end
            end
            if (c < 9) tick;
        end
        checks++;
        if (n_iter != 8) begin
            errors++; $display("FAIL mul_iters: got %0d want 8", n_iter);
        end
        tick;
        checks++;
        if (done !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL mul_after: done=%b pending=%0d want 0/0", done, sb.size());
        end
        $display("test_mul: %0d iterations", n_iter);
    endtask

    task automatic test_div_overlap;
        exp_t e;
        alu_op = 2'b10; func = 6'b011010; start = 1'b1;
        sb.push_back('{op: 4'b1001, err: 1'b0});
        tick;
        func = 6'b100000;
        for (int c = 1; c <= 14; c++) begin
            start = (c <= 12);
            if (c >= 9 && c <= 12) sb.push_back('{op: 4'b0010, err: 1'b0});
            checks++;
            if (stall !== (c <= 8)) begin
                errors++; $display("FAIL div_stall[c%0d]: got %b want %b", c, stall, c <= 8);
            end
            checks++;
            if (done !== (c >= 9 && c <= 13)) begin
                errors++; $display("FAIL div_done[c%0d]: got %b want %b", c, done, c >= 9 && c <= 13);
            end
            if (c <= 8) begin
                checks++;
                if (operation !== 4'b1001) begin
                    errors++; $display("FAIL div_op[c%0d]: got %b want 1001", c, operation);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL div_sb[c%0d]: unexpected done, got op=%b want none", c, operation);
                end else begin
                    e = sb.pop_front();
                    if (operation !== e.op || err !== e.err) begin
                        errors++; $display("FAIL div_result[c%0d]: got op=%b err=%b want op=%b err=%b",
                                           c, operation, err, e.op, e.err);
                    end
                end
            end
            $display("div cycle %0d: stall=%b done=%b op=%b", c, stall, done, operation);
            tick;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL div_after: done=%b pending=%0d want 0/0", done, sb.size());
        end
    endtask

    task automatic test_illegal;
        exp_t e;
        alu_op = 2'b10; func = 6'b000101; start = 1'b1;
        sb.push_back('{op: 4'b1111, err: 1'b1});
        tick;
        alu_op = 2'b00;
        sb.push_back('{op: 4'b0010, err: 1'b0});
        for (int i = 0; i < 2; i++) begin
            checks++;
            e = sb.pop_front();
            if (done !== 1'b1 || operation !== e.op || err !== e.err) begin
                errors++; $display("FAIL illegal[%0d]: got done=%b op=%b err=%b want 1 %b %b",
                                   i, done, operation, err, e.op, e.err);
            end
            $display("illegal %0d: op=%b done=%b err=%b", i, operation, done, err);
            if (i == 0) tick;
        end
        start = 1'b0;
        tick;
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || operation !== 4'b0010) begin
            errors++; $display("FAIL illegal_hold: got done=%b err=%b op=%b want 0 0 0010", done, err, operation);
        end
    endtask

    task automatic test_mid_reset;
        exp_t e;
        int lat, n_iter;
        alu_op = 2'b10; func = 6'b011000; start = 1'b1;
        sb.push_back('{op: 4'b1000, err: 1'b0});
        tick;
        start = 1'b0;
        tick; tick; tick;
        checks++;
        if (iter_en !== 1'b1 || iter_first !== 1'b0) begin
            errors++; $display("FAIL midrst_iter4: got en=%b first=%b want 1 0", iter_en, iter_first);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        sb.delete();
        checks++;
        if ({operation, iter_en, iter_first, iter_last, stall, done, err} !== 10'b1111_000000) begin
            errors++; $display("FAIL midrst_state: got %b want 1111000000",
                               {operation, iter_en, iter_first, iter_last, stall, done, err});
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (done !== 1'b0 || stall !== 1'b0) begin
                errors++; $display("FAIL midrst_quiet[%0d]: got done=%b stall=%b want 0 0", i, done, stall);
            end
        end
        start = 1'b1;
        sb.push_back('{op: 4'b1000, err: 1'b0});
        tick;
        start = 1'b0;
        lat = 1; n_iter = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (iter_en === 1'b1) n_iter++;
            tick;
            lat++;
        end
        checks++;
        if (lat != 9 || n_iter != 8) begin
            errors++; $display("FAIL midrst_fresh: got lat=%0d iters=%0d want 9 8", lat, n_iter);
        end
        checks++;
        e = sb.pop_front();
        if (operation !== e.op || err !== e.err) begin
            errors++; $display("FAIL midrst_result: got op=%b err=%b want %b %b", operation, err, e.op, e.err);
        end
        $display("mid-reset fresh MUL: latency %0d, %0d iterations", lat, n_iter);
        tick;
    endtask

    task automatic test_data_w16;
        exp_t e;
        int lat, n_iter, first_c, last_c;
        alu_op16 = 2'b10; func16 = 6'b011000; start16 = 1'b1;
        tick;
        start16 = 1'b0;
        tick; tick; tick;
        rst16 = 1'b1;
        tick;
        rst16 = 1'b0;
        checks++;
        if ({operation16, iter_en16, stall16, done16} !== 7'b1111000) begin
            errors++; $display("FAIL w16_midrst: got %b want 1111000",
                               {operation16, iter_en16, stall16, done16});
        end
        start16 = 1'b1;
        sb.push_back('{op: 4'b1000, err: 1'b0});
        tick;
        start16 = 1'b0;
        lat = 1; n_iter = 0; first_c = 0; last_c = 0;
        while (done16 !== 1'b1 && lat < 60) begin
            if (iter_en16 === 1'b1) n_iter++;
            if (iter_first16 === 1'b1) first_c = (first_c == 0) ? lat : -1;
            if (iter_last16 === 1'b1) last_c = (last_c == 0) ? lat : -1;
            tick;
            lat++;
        end
        checks++;
        if (lat != 17 || n_iter != 16) begin
            errors++; $display("FAIL w16_latency: got lat=%0d iters=%0d want 17 16", lat, n_iter);
        end
        checks++;
        if (first_c != 1 || last_c != 16) begin
            errors++; $display("FAIL w16_markers: got first=%0d last=%0d want 1 16", first_c, last_c);
        end
        checks++;
        e = sb.pop_front();
        if (operation16 !== e.op || err16 !== e.err) begin
            errors++; $display("FAIL w16_result: got op=%b err=%b want %b %b", operation16, err16, e.op, e.err);
        end
        $display("DATA_W=16 MUL: latency %0d, %0d iterations", lat, n_iter);
        tick;
    endtask

    initial begin
        test_reset;
        test_single_ops;
        test_mul;
        test_div_overlap;
        test_illegal;
        test_mid_reset;
        test_data_w16;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_control_mc.md
Name: alu_control_mc

Overview:
Next-generation ALU control unit for the microprocessor datapath. Adds registered, handshaked decode of ALUOp/func and multi-cycle sequencing for MUL and DIV. MUL is built as shift-add steps and DIV as restoring steps, each taking DATA_W iterations. Sits between the main control unit, which issues start, and the ALU/multiplier datapath, which consumes operation, iter_en, iter_first and iter_last. stall feeds the pipeline/PC hazard logic.

Parameters:
DATA_W, 8, datapath width; also the iteration count for MUL/DIV (must be >= 2)
FUNC_W, 6, width of the R-type func field
OP_W, 4, width of the operation code driven to the ALU
CNT_W, $clog2(DATA_W), iteration counter width

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  issue strobe; ALUOp/func sampled when start=1 and stall=0
ALUOp  input  2  00 load/store add, 01 branch sub, 10 R-type (use func), 11 immediate OR
func  input  FUNC_W  R-type function field
operation  output  OP_W  registered ALU operation code
iter_en  output  1  datapath performs one MUL/DIV step this cycle
iter_first  output  1  first iteration; datapath loads operands
iter_last  output  1  final iteration
stall  output  1  unit busy; upstream must hold the instruction
done  output  1  one-cycle pulse: result valid this cycle
err  output  1  one-cycle pulse with done: illegal func

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Operation codes are package constants:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111
  - MUL 1000, DIV 1001, NOR 1100, NOP 1111
- Decode for ALUOp=10, by func:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR
  - 100111 NOR, 101010 SLT, 011000 MUL, 011010 DIV
  - any other value is illegal.
- Decode for other ALUOp: 00 ADD, 01 SUB, 11 OR.
- Reset values: state=IDLE, operation=NOP, counter=0; iter_en, iter_first, iter_last, stall, done, err all 0.
- FSM states: IDLE, ITER, FIN.
- IDLE, start=1, single-cycle op:
  - next cycle: operation=decoded code, done=1, remain in IDLE.
  - latency is 1 cycle.
- IDLE, start=1, illegal func:
  - next cycle: operation=NOP, done=1, err=1, remain in IDLE.
- IDLE, start=1, MUL/DIV:
  - next cycle: enter ITER with operation=MUL/DIV, counter=0, iter_en=1, iter_first=1, stall=1.
- ITER:
  - iter_en=1 every cycle; counter increments each cycle.
  - iter_first=1 only when counter=0.
  - iter_last=1 when counter=DATA_W-1; the same edge moves to FIN.
- FIN:
  - done=1, stall=0, iter_en=0, operation held; next state IDLE.
  - total latency start->done is DATA_W+1 cycles.
- stall:
  - 1 throughout ITER, 0 in IDLE and FIN.
  - start while stall=1 is ignored: no queueing, no error.
- start in the FIN cycle is accepted as a normal IDLE issue (back-to-back issue allowed).
- operation holds its last value between instructions. With no start, done stays 0.
- rst in any state returns to IDLE at that edge with reset values. It does not produce done and discards any partial MUL/DIV.
- The counter never wraps: it is cleared on ITER entry and only compared against DATA_W-1.
- start=1 with rst=1 on the same edge: rst wins and the instruction is dropped.

Decomposition:
- Package alu_ctrl_pkg holds:
  - the operation code constants
  - the func code constants
  - the ALUOp encodings
  - the FSM state encoding (IDLE/ITER/FIN)
- One sub-module, alu_func_decode, is natural: purely combinational ALUOp/func -> {op code, is_multi, illegal}. It is instantiated once. The FSM, counter and output registers stay in alu_control_mc.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 -> operation=1111; stall, done, err, iter_en all 0.
- Single-cycle ops: start pulses with (00,x), (01,x), (11,x), and (10, each of the six legal func values) -> one cycle later operation=0010, 0110, 0001, then 0010/0110/0000/0001/1100/0111; done=1 each time; stall never asserted.
- MUL, DATA_W=8: start with ALUOp=10, func=011000 ->
  - iter_en high for exactly 8 cycles
  - iter_first in cycle 1 only, iter_last in cycle 8 only
  - done in cycle 9, operation=1000 throughout.
- DIV with overlapping starts: start with func=011010, then start=1 every cycle for 12 cycles ->
  - extra starts ignored while stall=1
  - the start coinciding with FIN is accepted, giving its done at cycle 10 (FIN at cycle 9).
- Illegal func: ALUOp=10, func=000101 -> next cycle operation=1111, done=1, err=1. Repeat with ALUOp=00 and the same func -> ADD, err=0.
- Mid-operation reset: rst=1 for one cycle at iteration 4 of a MUL -> next cycle all outputs at reset values, no done. A fresh MUL then completes in 9 cycles. Rerun with DATA_W=16 -> 16 iterations, done at cycle 17.
